// File: rtl/control_multi_if.sv
// rtl/control_multi_if.sv - datapath bus between the multicycle control unit and the RV32I datapath
interface control_multi_if;
    logic [31:0] iInstr;
    logic        iMemReady;
    logic        iBranchTaken;

    logic [5:0]  oState;
    logic        oPCWrite;
    logic        oIRWrite;
    logic        oOldPCWrite;
    logic        oRegWrite;
    logic        oMemRead;
    logic        oMemWrite;
    logic        oIorD;
    logic [1:0]  oOrigAULA;
    logic [1:0]  oOrigBULA;
    logic [1:0]  oALUOp;
    logic [1:0]  oMem2Reg;
    logic [1:0]  oOrigPC;

    modport master (
        input  iInstr, iMemReady, iBranchTaken,
        output oState, oPCWrite, oIRWrite, oOldPCWrite, oRegWrite, oMemRead, oMemWrite,
               oIorD, oOrigAULA, oOrigBULA, oALUOp, oMem2Reg, oOrigPC
    );

    modport slave (
        output iInstr, iMemReady, iBranchTaken,
        input  oState, oPCWrite, oIRWrite, oOldPCWrite, oRegWrite, oMemRead, oMemWrite,
               oIorD, oOrigAULA, oOrigBULA, oALUOp, oMem2Reg, oOrigPC
    );
endinterface

// File: rtl/control_multi.sv
// rtl/control_multi.sv - multicycle RV32I control FSM with memory wait timeout, sticky status and counters
module control_multi #(
    parameter bit          HAS_M        = 1'b1,
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic             clockCPU,
    input  logic             reset,
    control_multi_if.master  bus,
    output logic             oHalt,
    output logic             oInvInstruction,
    output logic             oBusError,
    output logic [CNT_W-1:0] oCycleCount,
    output logic [CNT_W-1:0] oInstret
);

    typedef enum logic [5:0] {
        FETCH   = 6'd0,
        DECODE  = 6'd1,
        MEMADDR = 6'd2,
        MEMRD   = 6'd3,
        MEMWB   = 6'd4,
        MEMWR   = 6'd5,
        EXEC_R  = 6'd6,
        EXEC_I  = 6'd7,
        ALUWB   = 6'd8,
        BRANCH  = 6'd9,
        JAL     = 6'd10,
        JALR    = 6'd11,
        LUI     = 6'd12,
        AUIPC   = 6'd13,
        HALT    = 6'd14,
        TRAP    = 6'd15
    } state_t;

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t            state;
    state_t            stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic              memWait;
    logic              timeout;
    logic              decodeTrap;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic              rLegal;

    assign opcode = bus.iInstr[6:0];
    assign funct7 = bus.iInstr[31:25];
    assign rLegal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                    ((funct7 == 7'b0000001) && HAS_M);

    // A waiting access whose next idle cycle would reach the limit traps instead.
    assign memWait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !bus.iMemReady;
    assign timeout = (MEM_WAIT_MAX != 0) && memWait && (waitCnt == WAIT_LAST);

    always_comb begin
        stateNext = state;
        case (state)
            FETCH: begin
                if (bus.iMemReady)  stateNext = DECODE;
                else if (timeout)   stateNext = TRAP;
            end
            DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: stateNext = MEMADDR;
                    7'b0110011:             stateNext = rLegal ? EXEC_R : TRAP;
                    7'b0010011:             stateNext = EXEC_I;
                    7'b1100011:             stateNext = BRANCH;
                    7'b1101111:             stateNext = JAL;
                    7'b1100111:             stateNext = JALR;
                    7'b0110111:             stateNext = LUI;
                    7'b0010111:             stateNext = AUIPC;
                    7'b1110011:             stateNext = (bus.iInstr == 32'h0000_0073) ? HALT : TRAP;
                    default:                stateNext = TRAP;
                endcase
            end
            MEMADDR: stateNext = bus.iInstr[5] ? MEMWR : MEMRD;
            MEMRD: begin
                if (bus.iMemReady)  stateNext = MEMWB;
                else if (timeout)   stateNext = TRAP;
            end
            MEMWR: begin
                if (bus.iMemReady)  stateNext = FETCH;
                else if (timeout)   stateNext = TRAP;
            end
            EXEC_R, EXEC_I:                      stateNext = ALUWB;
            MEMWB, ALUWB, BRANCH, JAL, JALR,
            LUI, AUIPC:                          stateNext = FETCH;
            HALT:                                stateNext = HALT;
            TRAP:                                stateNext = TRAP;
            default:                             stateNext = TRAP;
        endcase
    end

    assign decodeTrap = (state == DECODE) && (stateNext == TRAP);

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state           <= FETCH;
            waitCnt         <= '0;
            oCycleCount     <= '0;
            oInstret        <= '0;
            oHalt           <= 1'b0;
            oInvInstruction <= 1'b0;
            oBusError       <= 1'b0;
        end else begin
            state <= stateNext;
            if (stateNext != state)
                waitCnt <= '0;
            else if (memWait)
                waitCnt <= waitCnt + 1'b1;
            if ((state != HALT) && (state != TRAP))
                oCycleCount <= oCycleCount + 1'b1;
            if ((state != FETCH) && (stateNext == FETCH))
                oInstret <= oInstret + 1'b1;
            if (stateNext == HALT)
                oHalt <= 1'b1;
            if (decodeTrap)
                oInvInstruction <= 1'b1;
            if (timeout)
                oBusError <= 1'b1;
        end
    end

    logic       pcWrite, irWrite, oldPCWrite, regWrite, memRead, memWrite, iorD;
    logic [1:0] origA, origB, aluOp, mem2Reg, origPC;

    always_comb begin
        pcWrite    = 1'b0;
        irWrite    = 1'b0;
        oldPCWrite = 1'b0;
        regWrite   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        origA      = 2'd0;
        origB      = 2'd0;
        aluOp      = 2'd0;
        mem2Reg    = 2'd0;
        origPC     = 2'd0;
        case (state)
            FETCH: begin
                memRead    = 1'b1;
                origA      = 2'd1;
                origB      = 2'd1;
                pcWrite    = bus.iMemReady;
                irWrite    = bus.iMemReady;
                oldPCWrite = bus.iMemReady;
            end
            DECODE: begin
                origA = 2'd2;
                origB = 2'd2;
            end
            MEMADDR: origB = 2'd2;
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                regWrite = 1'b1;
                mem2Reg  = 2'd2;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXEC_R: aluOp = 2'd2;
            EXEC_I: begin
                origB = 2'd2;
                aluOp = 2'd3;
            end
            ALUWB: regWrite = 1'b1;
            BRANCH: begin
                aluOp   = 2'd1;
                origPC  = 2'd1;
                pcWrite = bus.iBranchTaken;
            end
            JAL: begin
                regWrite = 1'b1;
                mem2Reg  = 2'd1;
                pcWrite  = 1'b1;
                origPC   = 2'd1;
            end
            JALR: begin
                origB    = 2'd2;
                regWrite = 1'b1;
                mem2Reg  = 2'd1;
                pcWrite  = 1'b1;
                origPC   = 2'd2;
            end
            LUI: begin
                regWrite = 1'b1;
                mem2Reg  = 2'd3;
            end
            AUIPC: regWrite = 1'b1;
            default: ;
        endcase
    end

    // Architectural write strobes are suppressed for as long as reset is held.
    assign bus.oState      = state;
    assign bus.oPCWrite    = pcWrite    && !reset;
    assign bus.oIRWrite    = irWrite    && !reset;
    assign bus.oOldPCWrite = oldPCWrite && !reset;
    assign bus.oRegWrite   = regWrite   && !reset;
    assign bus.oMemWrite   = memWrite   && !reset;
    assign bus.oMemRead    = memRead;
    assign bus.oIorD       = iorD;
    assign bus.oOrigAULA   = origA;
    assign bus.oOrigBULA   = origB;
    assign bus.oALUOp      = aluOp;
    assign bus.oMem2Reg    = mem2Reg;
    assign bus.oOrigPC     = origPC;

endmodule

// File: tb/tb_control_multi.sv
// tb/tb_control_multi.sv - directed self-checking bench for control_multi
module tb_control_multi;

    logic clk = 1'b0;
    logic rstA, rstB;
    always #5 clk = ~clk;

    control_multi_if busA();
    control_multi_if busB();

    logic        haltA, invA, busErrA;
    logic [63:0] cycA, instA;
    logic        haltB, invB, busErrB;
    logic [3:0]  cycB, instB;

    int nCompared   = 0;
    int nMismatched = 0;

    control_multi #(.HAS_M(1'b0), .CNT_W(64), .MEM_WAIT_MAX(15)) dutA (
        .clockCPU(clk), .reset(rstA), .bus(busA),
        .oHalt(haltA), .oInvInstruction(invA), .oBusError(busErrA),
        .oCycleCount(cycA), .oInstret(instA)
    );

    control_multi #(.HAS_M(1'b1), .CNT_W(4), .MEM_WAIT_MAX(4)) dutB (
        .clockCPU(clk), .reset(rstB), .bus(busB),
        .oHalt(haltB), .oInvInstruction(invB), .oBusError(busErrB),
        .oCycleCount(cycB), .oInstret(instB)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rstA = 1'b1;
        busA.iMemReady = 1'b1;
        #1;
        nCompared++; if (busA.oState !== 6'd0)   begin nMismatched++; $display("FAIL reset_state: got %0d want 0", busA.oState); end
        nCompared++; if (busA.oPCWrite !== 1'b0) begin nMismatched++; $display("FAIL reset_pcwrite: got %b want 0", busA.oPCWrite); end
        nCompared++; if (busA.oIRWrite !== 1'b0) begin nMismatched++; $display("FAIL reset_irwrite: got %b want 0", busA.oIRWrite); end
        tick(2);
        nCompared++; if (cycA !== 64'd0)  begin nMismatched++; $display("FAIL reset_cycle: got %0d want 0", cycA); end
        nCompared++; if (instA !== 64'd0) begin nMismatched++; $display("FAIL reset_instret: got %0d want 0", instA); end
        nCompared++; if ({haltA, invA, busErrA} !== 3'b000) begin nMismatched++; $display("FAIL reset_flags: got %b want 000", {haltA, invA, busErrA}); end
        rstA = 1'b0;
        busA.iInstr = 32'h0020A023;
        tick(3);
        nCompared++; if (busA.oState !== 6'd5)    begin nMismatched++; $display("FAIL abandon_in_memwr: got %0d want 5", busA.oState); end
        nCompared++; if (busA.oMemWrite !== 1'b1) begin nMismatched++; $display("FAIL abandon_memwrite_before: got %b want 1", busA.oMemWrite); end
        rstA = 1'b1;
        #1;
        nCompared++; if (busA.oMemWrite !== 1'b0) begin nMismatched++; $display("FAIL abandon_memwrite_reset: got %b want 0", busA.oMemWrite); end
        nCompared++; if (busA.oState !== 6'd0)    begin nMismatched++; $display("FAIL abandon_state: got %0d want 0", busA.oState); end
        rstA = 1'b0;
    endtask

    task automatic test_add;
        logic [5:0] expSt [5] = '{6'd0, 6'd1, 6'd6, 6'd8, 6'd0};
        logic       expRw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rstA = 1'b1; #1; rstA = 1'b0;
        busA.iInstr = 32'h002081B3;
        busA.iMemReady = 1'b1;
        #1;
        nCompared++; if ({busA.oPCWrite, busA.oIRWrite, busA.oOldPCWrite} !== 3'b111) begin nMismatched++; $display("FAIL add_fetch_strobes: got %b want 111", {busA.oPCWrite, busA.oIRWrite, busA.oOldPCWrite}); end
        nCompared++; if ({busA.oOrigAULA, busA.oOrigBULA} !== 4'b0101) begin nMismatched++; $display("FAIL add_fetch_alu_srcs: got %b want 0101", {busA.oOrigAULA, busA.oOrigBULA}); end
        for (int i = 0; i < 5; i++) begin
            nCompared++; if (busA.oState !== expSt[i])    begin nMismatched++; $display("FAIL add_state[%0d]: got %0d want %0d", i, busA.oState, expSt[i]); end
            nCompared++; if (busA.oRegWrite !== expRw[i]) begin nMismatched++; $display("FAIL add_regwrite[%0d]: got %b want %b", i, busA.oRegWrite, expRw[i]); end
            if (i == 2) begin
                nCompared++; if (busA.oALUOp !== 2'd2) begin nMismatched++; $display("FAIL add_aluop: got %0d want 2", busA.oALUOp); end
            end
            if (i < 4) tick(1);
        end
        nCompared++; if (instA !== 64'd1) begin nMismatched++; $display("FAIL add_instret: got %0d want 1", instA); end
        nCompared++; if (cycA !== 64'd4)  begin nMismatched++; $display("FAIL add_cycles: got %0d want 4", cycA); end
    endtask

    task automatic test_load_wait;
        logic [5:0] expSt [9] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd3, 6'd3, 6'd3, 6'd4, 6'd0};
        logic       rdy   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rstA = 1'b1; #1; rstA = 1'b0;
        busA.iInstr = 32'h0000A183;
        for (int i = 0; i < 9; i++) begin
            busA.iMemReady = rdy[i];
            #1;
            nCompared++; if (busA.oState !== expSt[i]) begin nMismatched++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, busA.oState, expSt[i]); end
            if (i == 4) begin
                nCompared++; if ({busA.oMemRead, busA.oIorD} !== 2'b11) begin nMismatched++; $display("FAIL lw_memrd_strobes: got %b want 11", {busA.oMemRead, busA.oIorD}); end
            end
            if (i == 7) begin
                nCompared++; if ({busA.oRegWrite, busA.oMem2Reg} !== 3'b110) begin nMismatched++; $display("FAIL lw_memwb: got %b want 110", {busA.oRegWrite, busA.oMem2Reg}); end
            end
            if (i < 8) tick(1);
        end
        nCompared++; if (cycA !== 64'd8)  begin nMismatched++; $display("FAIL lw_cycles: got %0d want 8", cycA); end
        nCompared++; if (instA !== 64'd1) begin nMismatched++; $display("FAIL lw_instret: got %0d want 1", instA); end
    endtask

    task automatic test_store;
        rstA = 1'b1; #1; rstA = 1'b0;
        busA.iInstr = 32'h0020A023;
        busA.iMemReady = 1'b1;
        tick(3);
        nCompared++; if (busA.oState !== 6'd5) begin nMismatched++; $display("FAIL sw_state: got %0d want 5", busA.oState); end
        nCompared++; if ({busA.oMemWrite, busA.oIorD, busA.oMemRead} !== 3'b110) begin nMismatched++; $display("FAIL sw_strobes: got %b want 110", {busA.oMemWrite, busA.oIorD, busA.oMemRead}); end
        tick(1);
        nCompared++; if (busA.oState !== 6'd0) begin nMismatched++; $display("FAIL sw_return: got %0d want 0", busA.oState); end
        nCompared++; if (cycA !== 64'd4)       begin nMismatched++; $display("FAIL sw_cycles: got %0d want 4", cycA); end
    endtask

    task automatic test_branch;
        rstA = 1'b1; #1; rstA = 1'b0;
        busA.iInstr = 32'h00208463;
        busA.iMemReady = 1'b1;
        busA.iBranchTaken = 1'b0;
        tick(2);
        #1;
        nCompared++; if (busA.oState !== 6'd9)    begin nMismatched++; $display("FAIL beq_state: got %0d want 9", busA.oState); end
        nCompared++; if (busA.oPCWrite !== 1'b0)  begin nMismatched++; $display("FAIL beq_nottaken_pcwrite: got %b want 0", busA.oPCWrite); end
        nCompared++; if ({busA.oOrigPC, busA.oALUOp} !== 4'b0101) begin nMismatched++; $display("FAIL beq_origpc_aluop: got %b want 0101", {busA.oOrigPC, busA.oALUOp}); end
        tick(3);
        busA.iBranchTaken = 1'b1;
        #1;
        nCompared++; if (busA.oPCWrite !== 1'b1) begin nMismatched++; $display("FAIL beq_taken_pcwrite: got %b want 1", busA.oPCWrite); end
        tick(1);
        nCompared++; if (instA !== 64'd2) begin nMismatched++; $display("FAIL beq_instret: got %0d want 2", instA); end
        nCompared++; if (cycA !== 64'd6)  begin nMismatched++; $display("FAIL beq_cycles: got %0d want 6", cycA); end
        busA.iBranchTaken = 1'b0;
    endtask

    task automatic test_jumps;
        logic [31:0] instr  [4] = '{32'h008000EF, 32'h000080E7, 32'h123450B7, 32'h00001097};
        logic [5:0]  expSt  [4] = '{6'd10, 6'd11, 6'd12, 6'd13};
        logic [1:0]  expM2R [4] = '{2'd1, 2'd1, 2'd3, 2'd0};
        logic [1:0]  expOPC [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        logic        expPCW [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            rstA = 1'b1; #1; rstA = 1'b0;
            busA.iInstr = instr[k];
            busA.iMemReady = 1'b1;
            tick(2);
            nCompared++; if (busA.oState !== expSt[k])    begin nMismatched++; $display("FAIL jump_state[%0d]: got %0d want %0d", k, busA.oState, expSt[k]); end
            nCompared++; if (busA.oMem2Reg !== expM2R[k]) begin nMismatched++; $display("FAIL jump_mem2reg[%0d]: got %0d want %0d", k, busA.oMem2Reg, expM2R[k]); end
            nCompared++; if (busA.oOrigPC !== expOPC[k])  begin nMismatched++; $display("FAIL jump_origpc[%0d]: got %0d want %0d", k, busA.oOrigPC, expOPC[k]); end
            nCompared++; if (busA.oPCWrite !== expPCW[k]) begin nMismatched++; $display("FAIL jump_pcwrite[%0d]: got %b want %b", k, busA.oPCWrite, expPCW[k]); end
            nCompared++; if (busA.oRegWrite !== 1'b1)     begin nMismatched++; $display("FAIL jump_regwrite[%0d]: got %b want 1", k, busA.oRegWrite); end
            tick(1);
            nCompared++; if (instA !== 64'd1) begin nMismatched++; $display("FAIL jump_instret[%0d]: got %0d want 1", k, instA); end
        end
    endtask

    task automatic test_illegal;
        logic [31:0] instr [5] = '{32'h022081B3, 32'h042081B3, 32'h0000007F, 32'h00100073, 32'h402081B3};
        logic [5:0]  expSt [5] = '{6'd15, 6'd15, 6'd15, 6'd15, 6'd6};
        logic        expInv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            rstA = 1'b1; #1; rstA = 1'b0;
            busA.iInstr = instr[k];
            busA.iMemReady = 1'b1;
            tick(2);
            nCompared++; if (busA.oState !== expSt[k]) begin nMismatched++; $display("FAIL illegal_state[%0d]: got %0d want %0d", k, busA.oState, expSt[k]); end
            nCompared++; if (invA !== expInv[k])       begin nMismatched++; $display("FAIL illegal_inv[%0d]: got %b want %b", k, invA, expInv[k]); end
            nCompared++; if (busErrA !== 1'b0)         begin nMismatched++; $display("FAIL illegal_buserr[%0d]: got %b want 0", k, busErrA); end
        end
        tick(2);
        nCompared++; if (cycA !== 64'd4) begin nMismatched++; $display("FAIL illegal_tail_cycles: got %0d want 4", cycA); end
        rstB = 1'b1; #1; rstB = 1'b0;
        busB.iInstr = 32'h022081B3;
        busB.iMemReady = 1'b1;
        tick(2);
        nCompared++; if (busB.oState !== 6'd6) begin nMismatched++; $display("FAIL mul_hasm_state: got %0d want 6", busB.oState); end
        nCompared++; if (invB !== 1'b0)        begin nMismatched++; $display("FAIL mul_hasm_inv: got %b want 0", invB); end
    endtask

    task automatic test_bus_error;
        rstB = 1'b1; #1; rstB = 1'b0;
        busB.iInstr = 32'h002081B3;
        busB.iMemReady = 1'b0;
        tick(3);
        nCompared++; if (busB.oState !== 6'd0) begin nMismatched++; $display("FAIL timeout_pre_state: got %0d want 0", busB.oState); end
        nCompared++; if (busErrB !== 1'b0)     begin nMismatched++; $display("FAIL timeout_pre_flag: got %b want 0", busErrB); end
        tick(1);
        nCompared++; if (busB.oState !== 6'd15) begin nMismatched++; $display("FAIL timeout_state: got %0d want 15", busB.oState); end
        nCompared++; if ({busErrB, invB} !== 2'b10) begin nMismatched++; $display("FAIL timeout_flags: got %b want 10", {busErrB, invB}); end
        nCompared++; if (cycB !== 4'd4)         begin nMismatched++; $display("FAIL timeout_cycles: got %0d want 4", cycB); end
        busB.iMemReady = 1'b1;
        tick(3);
        nCompared++; if ({cycB, instB} !== {4'd4, 4'd0}) begin nMismatched++; $display("FAIL timeout_frozen: got %0d/%0d want 4/0", cycB, instB); end
        nCompared++; if ({busB.oPCWrite, busB.oMemRead, busB.oRegWrite} !== 3'b000) begin nMismatched++; $display("FAIL trap_strobes: got %b want 000", {busB.oPCWrite, busB.oMemRead, busB.oRegWrite}); end
        rstB = 1'b1; #1; rstB = 1'b0;
        busB.iMemReady = 1'b0;
        tick(3);
        busB.iMemReady = 1'b1;
        #1;
        nCompared++; if (busB.oPCWrite !== 1'b1) begin nMismatched++; $display("FAIL ready_wins_pcwrite: got %b want 1", busB.oPCWrite); end
        tick(1);
        nCompared++; if ({busB.oState, busErrB} !== {6'd1, 1'b0}) begin nMismatched++; $display("FAIL ready_wins_state: got %0d/%b want 1/0", busB.oState, busErrB); end
    endtask

    task automatic test_wrap;
        rstB = 1'b1; #1; rstB = 1'b0;
        busB.iInstr = 32'h002081B3;
        busB.iMemReady = 1'b1;
        tick(24);
        nCompared++; if (cycB !== 4'd8)  begin nMismatched++; $display("FAIL wrap_cycles: got %0d want 8", cycB); end
        nCompared++; if (instB !== 4'd6) begin nMismatched++; $display("FAIL wrap_instret: got %0d want 6", instB); end
        nCompared++; if (busB.oState !== 6'd0) begin nMismatched++; $display("FAIL wrap_state: got %0d want 0", busB.oState); end
    endtask

    task automatic test_halt;
        rstA = 1'b1; #1; rstA = 1'b0;
        busA.iInstr = 32'h00000073;
        busA.iMemReady = 1'b1;
        tick(2);
        nCompared++; if (busA.oState !== 6'd14) begin nMismatched++; $display("FAIL halt_state: got %0d want 14", busA.oState); end
        nCompared++; if ({haltA, invA} !== 2'b10) begin nMismatched++; $display("FAIL halt_flags: got %b want 10", {haltA, invA}); end
        tick(3);
        nCompared++; if ({cycA, instA} !== {64'd2, 64'd0}) begin nMismatched++; $display("FAIL halt_frozen: got %0d/%0d want 2/0", cycA, instA); end
        nCompared++; if ({busA.oPCWrite, busA.oMemRead} !== 2'b00) begin nMismatched++; $display("FAIL halt_strobes: got %b want 00", {busA.oPCWrite, busA.oMemRead}); end
        #2;
        rstA = 1'b1;
        #1;
        nCompared++; if (busA.oState !== 6'd0) begin nMismatched++; $display("FAIL halt_async_state: got %0d want 0", busA.oState); end
        nCompared++; if ({cycA, haltA} !== {64'd0, 1'b0}) begin nMismatched++; $display("FAIL halt_async_clear: got %0d/%b want 0/0", cycA, haltA); end
        rstA = 1'b0;
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        busA.iInstr = 32'h0; busA.iMemReady = 1'b0; busA.iBranchTaken = 1'b0;
        busB.iInstr = 32'h0; busB.iMemReady = 1'b0; busB.iBranchTaken = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_bus_error();
        test_wrap();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
